// File: rtl/aes_rcon_seq_if.sv
// Handshake bundle between the key-schedule controller (master) and the
// round-constant sequencer (slave).
interface aes_rcon_seq_if #(
  parameter int RCON_W = 32
);
  logic              start;
  logic [1:0]        mode;
  logic              adv;
  logic              abort;
  logic [RCON_W-1:0] rcon_val;
  logic [3:0]        round_num;
  logic              rcon_valid;
  logic              rcon_last;
  logic [3:0]        num_rounds;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, mode, adv, abort,
    input  rcon_val, round_num, rcon_valid, rcon_last, num_rounds, busy, done, err
  );

  modport slave (
    input  start, mode, adv, abort,
    output rcon_val, round_num, rcon_valid, rcon_last, num_rounds, busy, done, err
  );
endinterface

// File: rtl/aes_rcon_seq.sv
// AES round-constant sequencer: steps the Rcon byte through GF(2^8) xtime
// once per consumer advance, with per-key-size round limits.
//
// state | meaning
// IDLE  | no sequence active; waits for a legal start
// RUN   | rcon_val/round_num valid; advances on adv, exits on last adv or abort
module aes_rcon_seq #(
  parameter int RCON_W    = 32,
  parameter bit ALIGN_MSB = 1'b1
) (
  input logic          clk,
  input logic          rst,
  aes_rcon_seq_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] byte_q;
  logic [3:0] round_q;
  logic [3:0] limit_q;
  logic [3:0] nr_q;
  logic       done_q;
  logic       err_q;

  logic       accept;
  logic       reject;
  logic       step;
  logic       finish;
  logic       kill;
  logic [3:0] limit_sel;
  logic [3:0] nr_sel;
  logic [7:0] byte_next;
  logic [RCON_W-1:0] rcon_pos;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Rcon count and cipher round count for the requested key size.
  always_comb begin
    limit_sel = 4'd10;
    nr_sel    = 4'd10;
    case (bus.mode)
      2'b01: begin
        limit_sel = 4'd8;
        nr_sel    = 4'd12;
      end
      2'b10: begin
        limit_sel = 4'd7;
        nr_sel    = 4'd14;
      end
      default: begin
        limit_sel = 4'd10;
        nr_sel    = 4'd10;
      end
    endcase
  end

  assign byte_next = xtime(byte_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; abort outranks adv, and abort also masks start in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    kill    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.mode == 2'b11) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          kill    = 1'b1;
          state_d = IDLE;
        end else if (bus.adv) begin
          if (round_q == limit_q) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rcon byte, round index, latched limits and the one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q  <= 8'h00;
      round_q <= 4'd0;
      limit_q <= 4'd0;
      nr_q    <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= finish;
      err_q  <= reject;
      if (accept) begin
        byte_q  <= 8'h01;
        round_q <= 4'd1;
        limit_q <= limit_sel;
        nr_q    <= nr_sel;
      end else if (kill || finish) begin
        byte_q  <= 8'h00;
        round_q <= 4'd0;
      end else if (step) begin
        byte_q  <= byte_next;
        round_q <= round_q + 4'd1;
      end
    end
  end

  // Place the Rcon byte at the top or bottom of the word; other bits stay zero.
  always_comb begin
    rcon_pos = '0;
    if (ALIGN_MSB) begin
      rcon_pos[RCON_W-1 -: 8] = byte_q;
    end else begin
      rcon_pos[7:0] = byte_q;
    end
  end

  // Outputs derived from registered state only.
  always_comb begin
    bus.rcon_val   = rcon_pos;
    bus.round_num  = round_q;
    bus.rcon_valid = (state_q == RUN);
    bus.busy       = (state_q == RUN);
    bus.rcon_last  = (state_q == RUN) && (round_q == limit_q);
    bus.num_rounds = nr_q;
    bus.done       = done_q;
    bus.err        = err_q;
  end

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Scoreboard bench for aes_rcon_seq: the driver predicts every cycle's outputs
// from a table-driven model, the monitor compares what the DUT shows.
module tb_aes_rcon_seq;

  typedef struct packed {
    logic        valid;
    logic [31:0] val;
    logic [3:0]  rnd;
    logic        last;
    logic [3:0]  nr;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  aes_rcon_seq_if #(.RCON_W(32)) bus ();

  aes_rcon_seq #(.RCON_W(32), .ALIGN_MSB(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Published AES round constants and per-key-size counts.
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  int lim_tab [3] = '{10, 8, 7};
  int nr_tab  [3] = '{10, 12, 14};

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  bit   m_active = 1'b0;
  int   m_idx    = 0;
  int   m_lim    = 0;
  int   m_nr     = 0;

  // One clock of stimulus: apply inputs, advance the model, queue the prediction.
  task automatic cyc(input bit r, input bit s, input logic [1:0] md, input bit a, input bit ab);
    exp_t e;
    bit   d, er;
    @(negedge clk);
    rst       = r;
    bus.start = s;
    bus.mode  = md;
    bus.adv   = a;
    bus.abort = ab;
    d  = 1'b0;
    er = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_idx    = 0;
      m_nr     = 0;
    end else if (!m_active) begin
      if (s && !ab) begin
        if (md == 2'b11) begin
          er = 1'b1;
        end else begin
          m_active = 1'b1;
          m_idx    = 1;
          m_lim    = lim_tab[md];
          m_nr     = nr_tab[md];
        end
      end
    end else begin
      if (ab) begin
        m_active = 1'b0;
        m_idx    = 0;
      end else if (a) begin
        if (m_idx == m_lim) begin
          m_active = 1'b0;
          m_idx    = 0;
          d        = 1'b1;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end
    e.valid = m_active;
    e.val   = m_active ? {rcon_tab[m_idx-1], 24'h000000} : 32'h0;
    e.rnd   = 4'(m_idx);
    e.last  = m_active && (m_idx == m_lim);
    e.nr    = 4'(m_nr);
    e.busy  = m_active;
    e.done  = d;
    e.err   = er;
    sb.push_back(e);
  endtask

  task automatic run_mode(input logic [1:0] md);
    cyc(0, 1, md, 0, 0);
    for (int k = 0; k < 20 && m_active; k++) cyc(0, 0, md, 1, 0);
    cyc(0, 0, 2'b00, 0, 0);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction each cycle.
  initial begin
    exp_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act.valid = bus.rcon_valid;
        act.val   = bus.rcon_val;
        act.rnd   = bus.round_num;
        act.last  = bus.rcon_last;
        act.nr    = bus.num_rounds;
        act.busy  = bus.busy;
        act.done  = bus.done;
        act.err   = bus.err;
        tests++;
        if (act !== e) begin
          failed++;
          $display("FAIL outputs t=%0t got valid=%b val=%h rnd=%0d last=%b nr=%0d busy=%b done=%b err=%b want valid=%b val=%h rnd=%0d last=%b nr=%0d busy=%b done=%b err=%b",
                   $time, act.valid, act.val, act.rnd, act.last, act.nr, act.busy, act.done, act.err,
                   e.valid, e.val, e.rnd, e.last, e.nr, e.busy, e.done, e.err);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    bit stalled;
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    bus.adv   = 1'b0;
    bus.abort = 1'b0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Full sequences for each key size with adv held high.
    run_mode(2'b00);
    run_mode(2'b01);
    run_mode(2'b10);

    // Random adv with a 5-cycle stall at round 4.
    cyc(0, 1, 2'b00, 0, 0);
    stalled = 1'b0;
    for (int k = 0; k < 200 && m_active; k++) begin
      if (m_idx == 4 && !stalled) begin
        repeat (5) cyc(0, 0, 2'b00, 0, 0);
        stalled = 1'b1;
      end else begin
        cyc(0, 0, 2'b00, 1'($urandom % 2), 0);
      end
    end
    cyc(0, 0, 2'b00, 0, 0);

    // Abort after third adv, restart, then abort together with adv.
    cyc(0, 1, 2'b00, 0, 0);
    repeat (3) cyc(0, 0, 2'b00, 1, 0);
    cyc(0, 0, 2'b00, 0, 1);
    cyc(0, 0, 2'b00, 1, 1);
    cyc(0, 1, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 1, 0);
    cyc(0, 0, 2'b00, 1, 1);
    cyc(0, 0, 2'b00, 1, 0);

    // Illegal mode, start+abort in IDLE, start ignored mid-run.
    cyc(0, 1, 2'b11, 0, 0);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 1, 2'b01, 0, 1);
    cyc(0, 1, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 1, 0);
    cyc(0, 0, 2'b00, 1, 0);
    cyc(0, 1, 2'b10, 1, 0);
    cyc(0, 1, 2'b11, 0, 0);
    for (int k = 0; k < 20 && m_active; k++) cyc(0, 0, 2'b10, 1, 0);

    // Reset mid-run, then start in the cycle done is high.
    cyc(0, 1, 2'b00, 0, 0);
    repeat (4) cyc(0, 0, 2'b00, 1, 0);
    cyc(1, 0, 2'b00, 1, 0);
    cyc(0, 1, 2'b10, 0, 0);
    for (int k = 0; k < 20 && m_active; k++) cyc(0, 0, 2'b10, 1, 0);
    cyc(0, 1, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 1, 0);
    cyc(0, 0, 2'b00, 0, 0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom % 60 == 0), 1'($urandom % 4 == 0), 2'($urandom % 4),
          1'($urandom % 2), 1'($urandom % 15 == 0));
    end
    repeat (3) cyc(0, 0, 2'b00, 0, 0);

    @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/aes_rcon_seq.md
Name: aes_rcon_seq

Overview:
- Sequential round-constant generator for the AES key-expansion engine. It replaces the fixed 1-to-10 lookup with a GF(2^8) xtime iterator.
- Supports AES-128, AES-192 and AES-256. Each key size needs a different number of Rcon values and a different total round count.
- Sits between the key-schedule controller, which issues start/adv, and the key-word datapath, which consumes rcon_val.
- Outputs are registered; stalls and aborts are handled through a simple valid/advance handshake.

Parameters:
- RCON_W, 32: width of rcon_val. Must be >= 8.
- ALIGN_MSB, 1: Rcon byte placement in rcon_val. 1 = bits [RCON_W-1:RCON_W-8]. 0 = bits [7:0]. All other bits are 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a sequence. Accepted only in IDLE.
- mode  in  2  key size, sampled on an accepted start. 00 = 128, 01 = 192, 10 = 256, 11 = illegal.
- adv  in  1  consumer has used the current rcon_val; step to the next value.
- abort  in  1  terminate the current sequence immediately.
- rcon_val  out  RCON_W  current round constant, positioned per ALIGN_MSB.
- round_num  out  4  index of the current Rcon, 1-based. 0 when idle.
- rcon_valid  out  1  rcon_val/round_num are meaningful.
- rcon_last  out  1  current value is the final Rcon for the latched mode.
- num_rounds  out  4  cipher round count for the latched mode: 10, 12 or 14.
- busy  out  1  FSM is in RUN.
- done  out  1  one-cycle pulse after the final value is consumed.
- err  out  1  one-cycle pulse on start with mode = 11.

Behaviour:
- Reset (rst=1 at clk edge) forces state IDLE and drives every output to 0: rcon_val, round_num, rcon_valid, rcon_last, num_rounds, busy, done, err. Reset mid-RUN abandons the sequence with no done pulse.
- States: IDLE, RUN.
- IDLE → RUN on start=1, abort=0, mode≠11. On the next edge:
  - rcon byte = 0x01, round_num = 1, rcon_valid = 1, busy = 1.
  - Latency is start to first valid value = 1 cycle.
- Per-mode limits, latched on the accepted start:
  - 00: limit = 10, num_rounds = 10.
  - 01: limit = 8, num_rounds = 12.
  - 10: limit = 7, num_rounds = 14.
- start with mode = 11 in IDLE: err = 1 for exactly one cycle, state stays IDLE, other outputs unchanged.
- In RUN, adv=1 with round_num < limit, on the next edge:
  - rcon byte ← xtime(byte) = (byte<<1)[7:0] XOR (byte[7] ? 0x1B : 0x00).
  - round_num ← round_num + 1.
- In RUN, adv=0: all outputs hold. Stalls are unbounded.
- rcon_last = rcon_valid AND (round_num == limit). It is combinationally derived from registered state, so no extra latency.
- In RUN, adv=1 with round_num == limit, on the next edge:
  - State → IDLE; rcon_valid, busy, rcon_last, rcon_val, round_num → 0.
  - done = 1 for one cycle.
  - num_rounds holds its value until the next accepted start or reset.
- abort=1 in RUN, on the next edge: state → IDLE, outputs cleared as for completion, but done = 0.
- Priority, highest first: rst > abort > adv. abort together with adv means the abort wins and no done pulse occurs.
- abort in IDLE has no effect. abort=1 together with start=1 in IDLE: start ignored.
- start while in RUN is ignored: no restart and no err. mode changes during RUN are ignored.
- adv while in IDLE is ignored.
- Back-to-back: start may be asserted in the same cycle that done is high (state already IDLE). It is accepted normally.
- Register width: round_num is 4 bits; the maximum value reached is 10, so there is no wrap. The xtime result is always 8 bits.

Test Plan:
- Reset, then start with mode=00, adv held high → rcon byte sequence 01,02,04,08,10,20,40,80,1B,36 on consecutive cycles. rcon_last only with 36, round_num=10. done pulses the cycle after 36; num_rounds=10. With RCON_W=32 and ALIGN_MSB=1, the first value is 32'h01000000 and the last is 32'h36000000.
- mode=01 → 8 values ending 0x80, rcon_last at round_num=8, num_rounds=12. mode=10 → 7 values ending 0x40, rcon_last at round_num=7, num_rounds=14.
- mode=00 with adv toggled randomly, plus one 5-cycle stall at round 4 → value 0x08 held for all stall cycles. Sequence is otherwise identical to the first scenario; exactly one done pulse.
- Abort after the 3rd adv (rcon=0x08) → next cycle rcon_valid=0, busy=0, no done. A new start then restarts at 0x01. Repeat with abort and adv in the same cycle → no done.
- start with mode=11 → err high for one cycle, busy stays 0. start asserted mid-RUN with mode=10 → ignored, sequence continues with the original limit 10.
- rst asserted at round 5 → all outputs 0 next cycle, no done. start issued in the same cycle as a done pulse → rcon_valid=1 with 0x01 the following cycle.
